dmem_arbiter: RTL

- Two-requester controller in front of the single-port 256-word data memory.
- Port A is the CPU load/store stage; port B is the secondary master (DMA/debug loader).
- Arbitrates round-robin, sequences the memory read/write strobes over a fixed access window, captures read data, and returns a one-cycle ack per transaction.
- Out-of-range addresses are rejected without touching memory.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port data memory.
// Sequences strobes over a fixed access window and returns a one-cycle ack per transaction.
module dmem_arbiter #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_n;
  logic              gnt_q, gnt_n;   // 1 = port B granted
  logic              ptr_q, ptr_n;   // 1 = port B favoured on a tie
  logic              we_q, we_n;
  logic              err_q, err_n;
  logic [31:0]       addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              sel_b;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  // Next-state, grant selection and transaction latching
  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    ptr_n     = ptr_q;
    we_n      = we_q;
    err_n     = err_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    cnt_n     = cnt_q;
    sel_b     = (a_req && b_req) ? ptr_q : b_req;
    req_we    = sel_b ? b_we    : a_we;
    req_addr  = sel_b ? b_addr  : a_addr;
    req_wdata = sel_b ? b_wdata : a_wdata;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_n   = sel_b;
          we_n    = req_we;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          if (req_addr < 32'(DEPTH)) begin
            state_n = ACCESS;
            cnt_n   = CNT_W'(MEM_LAT - 1);
            err_n   = 1'b0;
          end else begin
            state_n = RESP;
            err_n   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_n = RESP;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        ptr_n   = ~gnt_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and latched transaction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      gnt_q   <= gnt_n;
      ptr_q   <= ptr_n;
      we_q    <= we_n;
      err_q   <= err_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      cnt_q   <= cnt_n;
    end
  end

  // Outputs registered from next-state values so they align with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      mem_addr  <= (state_n == ACCESS) ? addr_n  : '0;
      mem_wdata <= (state_n == ACCESS) ? wdata_n : '0;
      mem_write <= (state_n == ACCESS) &&  we_n;
      mem_read  <= (state_n == ACCESS) && !we_n;
      a_ack     <= (state_n == RESP) && !gnt_n;
      a_err     <= (state_n == RESP) && !gnt_n && err_n;
      b_ack     <= (state_n == RESP) &&  gnt_n;
      b_err     <= (state_n == RESP) &&  gnt_n && err_n;
      busy      <= (state_n != IDLE);
      if (state == ACCESS && cnt_q == '0 && !we_q) begin
        if (gnt_q) b_rdata <= mem_rdata;
        else       a_rdata <= mem_rdata;
      end
    end
  end

endmodule
